// File: rtl/point_sequencer.sv
// point_sequencer
// Sequences a rally: serve (one-cycle ball respawn), play, a timed freeze after
// each point, and a terminal match-over state. Point events are detected from
// score changes reported by the judge.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   score_player1/2   current scores from the judge (4-bit, unsigned)
//   flag_point        scorer tie-break when both scores change together (0 = p1)
//   endgame           match-over level from the judge
//   thirdtouched      touch-limit fault level from the judge
//   freeze            high while ball and player physics must hold position
//   respawn           one-cycle pulse: ball loads serve_x/serve_y, zero velocity
//   serve_side        0 = player 1 serves, 1 = player 2 serves
//   serve_x, serve_y  ball respawn coordinates
//   point_banner      01 = player 1 scored, 10 = player 2 scored (PAUSE only)
//   fault_banner      third-touch fault indicator
//   winner            00 = running, 01 = player 1 won, 10 = player 2 won
module point_sequencer #(
  parameter int PAUSE_CYCLES = 97_500_000,
  parameter int SERVE_X1     = 250,
  parameter int SERVE_X2     = 773,
  parameter int SERVE_Y      = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  score_player1,
  input  logic [3:0]  score_player2,
  input  logic        flag_point,
  input  logic        endgame,
  input  logic        thirdtouched,
  output logic        freeze,
  output logic        respawn,
  output logic        serve_side,
  output logic [11:0] serve_x,
  output logic [11:0] serve_y,
  output logic [1:0]  point_banner,
  output logic        fault_banner,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {SERVE, PLAY, PAUSE, OVER} state_t;

  localparam logic [26:0] PAUSE_LAST = 27'(PAUSE_CYCLES - 1);

  state_t      state;
  logic [26:0] counter;
  logic [3:0]  prev_p1;
  logic [3:0]  prev_p2;

  logic p1_changed;
  logic p2_changed;
  logic score_event;
  logic scorer;

  always_comb begin
    p1_changed  = (score_player1 != prev_p1);
    p2_changed  = (score_player2 != prev_p2);
    score_event = p1_changed | p2_changed;
    // flag_point only breaks the tie when both scores move in the same cycle
    scorer      = (p1_changed && p2_changed) ? flag_point : p2_changed;
  end

  // Reset also reloads prev_* with the live scores so nonzero judge reset
  // values do not look like a point.
  always_ff @(posedge clk) begin
    prev_p1 <= score_player1;
    prev_p2 <= score_player2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SERVE;
      counter      <= '0;
      serve_side   <= 1'b0;
      point_banner <= '0;
      fault_banner <= 1'b0;
      winner       <= '0;
      freeze       <= 1'b1;
      respawn      <= 1'b0;
      serve_x      <= 12'(SERVE_X1);
      serve_y      <= 12'(SERVE_Y);
    end else if (state != OVER) begin
      if (endgame) begin
        state        <= OVER;
        winner       <= (score_player1 > score_player2) ? 2'b01 : 2'b10;
        freeze       <= 1'b1;
        respawn      <= 1'b0;
        point_banner <= '0;
      end else if (score_event) begin
        state        <= PAUSE;
        counter      <= '0;
        serve_side   <= scorer;
        serve_x      <= scorer ? 12'(SERVE_X2) : 12'(SERVE_X1);
        point_banner <= scorer ? 2'b10 : 2'b01;
        freeze       <= 1'b1;
        respawn      <= 1'b0;
        if (state == PLAY && thirdtouched)
          fault_banner <= 1'b1;
      end else begin
        case (state)
          // SERVE is held with respawn low only straight out of reset; that
          // cycle arms the pulse so the first serve follows reset release.
          SERVE: begin
            if (respawn) begin
              state   <= PLAY;
              respawn <= 1'b0;
              freeze  <= 1'b0;
            end else begin
              respawn      <= 1'b1;
              freeze       <= 1'b1;
              fault_banner <= 1'b0;
            end
          end
          PLAY: begin
            if (thirdtouched)
              fault_banner <= 1'b1;
          end
          PAUSE: begin
            if (counter == PAUSE_LAST) begin
              state        <= SERVE;
              counter      <= '0;
              respawn      <= 1'b1;
              point_banner <= '0;
              fault_banner <= 1'b0;
            end else begin
              counter <= counter + 27'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_point_sequencer.sv
// Testbench for point_sequencer (PAUSE_CYCLES = 10).
// Reference model is timestamp-based: it records the cycle at which the next
// respawn is due and derives freeze/respawn/banners from the cycle index.
module tb_point_sequencer;

  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  score_player1;
  logic [3:0]  score_player2;
  logic        flag_point;
  logic        endgame;
  logic        thirdtouched;
  logic        freeze;
  logic        respawn;
  logic        serve_side;
  logic [11:0] serve_x;
  logic [11:0] serve_y;
  logic [1:0]  point_banner;
  logic        fault_banner;
  logic [1:0]  winner;

  point_sequencer #(
    .PAUSE_CYCLES(P),
    .SERVE_X1(250),
    .SERVE_X2(773),
    .SERVE_Y(300)
  ) dut (
    .clk(clk),
    .rst(rst),
    .score_player1(score_player1),
    .score_player2(score_player2),
    .flag_point(flag_point),
    .endgame(endgame),
    .thirdtouched(thirdtouched),
    .freeze(freeze),
    .respawn(respawn),
    .serve_side(serve_side),
    .serve_x(serve_x),
    .serve_y(serve_y),
    .point_banner(point_banner),
    .fault_banner(fault_banner),
    .winner(winner)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model
  int         m_resp;
  bit         m_over;
  bit         m_paused;
  bit         m_side;
  bit         m_fault;
  logic [1:0] m_win;
  logic [1:0] m_code;
  logic [3:0] m_p1;
  logic [3:0] m_p2;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Applies the inputs sampled at the edge that starts cycle cyc.
  task automatic model_edge();
    bit ev, c1, c2, playing, who;
    if (rst) begin
      m_resp = cyc + 1; m_over = 0; m_paused = 0; m_side = 0; m_fault = 0;
      m_win = 2'b00; m_code = 2'b00;
      m_p1 = score_player1; m_p2 = score_player2;
      return;
    end
    c1 = (score_player1 != m_p1);
    c2 = (score_player2 != m_p2);
    ev = c1 || c2;
    m_p1 = score_player1; m_p2 = score_player2;
    if (m_over) return;
    if (endgame) begin
      m_over = 1;
      m_win = (score_player1 > score_player2) ? 2'b01 : 2'b10;
      return;
    end
    playing = (cyc - 1) > m_resp;
    if (ev) begin
      who = (c1 && c2) ? flag_point : c2;
      m_side = who;
      m_code = who ? 2'b10 : 2'b01;
      m_resp = cyc + P;
      m_paused = 1;
    end
    if (cyc == m_resp) m_fault = 0;
    else if (playing && thirdtouched) m_fault = 1;
  endtask

  task automatic check_all();
    bit e_resp, e_freeze;
    logic [1:0] e_ban;
    e_resp   = !m_over && (cyc == m_resp);
    e_freeze = m_over || (cyc <= m_resp);
    e_ban    = (!m_over && m_paused && cyc < m_resp) ? m_code : 2'b00;
    chk("respawn", 12'(respawn), 12'(e_resp));
    chk("freeze", 12'(freeze), 12'(e_freeze));
    chk("point_banner", 12'(point_banner), 12'(e_ban));
    chk("serve_side", 12'(serve_side), 12'(m_side));
    chk("serve_x", serve_x, m_side ? 12'd773 : 12'd250);
    chk("serve_y", serve_y, 12'd300);
    chk("fault_banner", 12'(fault_banner), 12'(m_fault));
    chk("winner", 12'(winner), 12'(m_win));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    rst = 1'b1; score_player1 = 4'd3; score_player2 = 4'd0;
    flag_point = 1'b0; endgame = 1'b0; thirdtouched = 1'b0;

    // reset with judge scores 3/0, then a single player 1 serve
    tick(3);
    rst = 1'b0;
    tick(5);

    // player 2 scores from PLAY
    score_player2 = 4'd1;
    tick(15);

    // both change together, flag says player 1
    score_player1 = 4'd4; score_player2 = 4'd2; flag_point = 1'b0;
    tick(15);

    // flag says player 2 on a simultaneous change
    score_player1 = 4'd5; score_player2 = 4'd3; flag_point = 1'b1;
    tick(15);
    flag_point = 1'b0;

    // point, then another point at PAUSE cycle 5 restarts the freeze
    score_player2 = 4'd4;
    tick(5);
    score_player1 = 4'd6;
    tick(15);

    // third-touch fault in PLAY, then a point
    thirdtouched = 1'b1;
    tick(1);
    thirdtouched = 1'b0;
    tick(2);
    score_player2 = 4'd5;
    tick(15);

    // reset mid-PAUSE aborts the pending respawn
    score_player1 = 4'd7;
    tick(4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);

    // wrap 15 -> 0 counts as a change
    score_player2 = 4'd15;
    tick(13);
    score_player2 = 4'd0;
    tick(13);

    // 15/12 and endgame during PAUSE -> OVER, winner player 1
    score_player1 = 4'd15; score_player2 = 4'd12;
    tick(4);
    endgame = 1'b1;
    tick(3);
    score_player2 = 4'd13;
    tick(55);

    // reset out of OVER, then randomized play
    endgame = 1'b0; rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) score_player1 = score_player1 + 4'd1;
      if ($urandom_range(0, 24) == 0) score_player2 = score_player2 + 4'd1;
      flag_point   = 1'($urandom_range(0, 1));
      thirdtouched = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 699) == 0) endgame = 1'b1;
      rst = ($urandom_range(0, 399) == 0);
      if (rst) endgame = 1'b0;
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/point_sequencer.md
POINT_SEQUENCER -- requirements
Module: point_sequencer

Interface
REQ-001 Parameter PAUSE_CYCLES, default 97_500_000, post-point freeze length in clk cycles (1.5 s at 65 MHz); 27-bit counter.
REQ-002 Parameter SERVE_X1, default 250, ball respawn x for player 1 serve.
REQ-003 Parameter SERVE_X2, default 773, ball respawn x for player 2 serve.
REQ-004 Parameter SERVE_Y, default 300, ball respawn y for either side.
REQ-005 clk  input  1  system clock, 65 MHz.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 score_player1  input  4  player 1 score from judge.
REQ-008 score_player2  input  4  player 2 score from judge.
REQ-009 flag_point  input  1  judge scorer flag: 0 = player 1 scored, 1 = player 2 scored; may be X after reset.
REQ-010 endgame  input  1  judge match-over level.
REQ-011 thirdtouched  input  1  judge touch-limit fault level.
REQ-012 freeze  output  1  high = ball and player physics hold position.
REQ-013 respawn  output  1  one-cycle pulse: ball loads serve_x/serve_y with zero velocity.
REQ-014 serve_side  output  1  0 = player 1 serves, 1 = player 2 serves.
REQ-015 serve_x  output  12  respawn x; SERVE_X1 if serve_side=0, else SERVE_X2.
REQ-016 serve_y  output  12  respawn y, always SERVE_Y.
REQ-017 point_banner  output  2  01 = player 1 scored, 10 = player 2 scored, 00 = none; valid in PAUSE only.
REQ-018 fault_banner  output  1  third-touch fault indicator.
REQ-019 winner  output  2  00 = match running, 01 = player 1 won, 10 = player 2 won.

Function
REQ-020 States: SERVE, PLAY, PAUSE, OVER; all outputs registered.
REQ-021 prev_p1/prev_p2 registers track previous scores; score event = (score_player1 != prev_p1) or (score_player2 != prev_p2), evaluated every cycle; prev registers update every cycle.
REQ-022 Scorer on event: player 1 if only score_player1 changed, player 2 if only score_player2 changed, flag_point if both changed in the same cycle.
REQ-023 flag_point is ignored except in the both-changed case of REQ-022.
REQ-024 SERVE: respawn=1 and freeze=1 for exactly one cycle, then PLAY.
REQ-025 PLAY: freeze=0; score event -> PAUSE next cycle, counter cleared, serve_side <= scorer, point_banner <= scorer code.
REQ-026 PAUSE: freeze=1; counter increments each cycle; at counter == PAUSE_CYCLES-1 -> SERVE, point_banner <= 00.
REQ-027 Score event while in PAUSE: counter restarts at 0, serve_side and point_banner take the new scorer.
REQ-028 Score event while in SERVE: handled as in PLAY (next state PAUSE, no second respawn pulse).
REQ-029 endgame=1 in any state -> OVER next cycle, with priority over score events and counter expiry.
REQ-030 Entry to OVER: winner <= 01 if score_player1 > score_player2, else 10; freeze=1, respawn=0, point_banner=00.
REQ-031 OVER is terminal; only rst leaves it; winner holds.
REQ-032 fault_banner sets when thirdtouched=1 in PLAY, holds through PAUSE, clears on the cycle respawn is asserted.
REQ-033 Point sequence latency: score change at cycle N -> freeze=1 at N+1 -> respawn pulse at N+1+PAUSE_CYCLES -> freeze=0 at N+2+PAUSE_CYCLES.
REQ-034 Score comparisons are unsigned 4-bit; 15 -> 0 wrap counts as a change.

Reset
REQ-035 On rst: state=SERVE, counter=0, serve_side=0, point_banner=00, fault_banner=0, winner=00, freeze=1, respawn=0, serve_x=SERVE_X1, serve_y=SERVE_Y.
REQ-036 On rst: prev_p1/prev_p2 load the current score inputs, so judge reset values (e.g. 3/0) do not raise an event.
REQ-037 First cycle after rst release: respawn pulse, player 1 serve.
REQ-038 rst mid-PAUSE or in OVER aborts the sequence within one cycle; no pending respawn survives.

Verification (PAUSE_CYCLES=10)
REQ-039 Release rst with scores 3/0 -> single respawn pulse at serve_x=250, serve_y=300; no PAUSE entry.
REQ-040 In PLAY, score_player2 0->1 -> freeze=1 and point_banner=10 next cycle; respawn after 10 cycles with serve_x=773; then freeze=0.
REQ-041 Both scores change in one cycle with flag_point=0 -> serve_side=0, point_banner=01.
REQ-042 score_player1 increments at PAUSE cycle 5 -> counter restarts; respawn 10 cycles after the second event, serve_side=0.
REQ-043 Scores 15/12 with endgame=1 during PAUSE -> OVER, winner=01, freeze=1 held, no respawn for 50+ cycles.
REQ-044 thirdtouched pulse in PLAY, then score event -> fault_banner=1 through PAUSE, 0 on the respawn cycle.
